// File: rtl/or_in_stage.sv
// Operand-buffering OR stage: accepts (a, b) pairs into a DEPTH-entry FIFO and
// delivers the registered result a | b on a valid/ready output.
module or_in_stage #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_a,
  input  logic [WIDTH-1:0]           in_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_y,
  output logic [$clog2(DEPTH):0]     level,
  output logic [CNT_W-1:0]           txn_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } pair_t;

  pair_t            mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_y_q, out_y_d;
  logic [CNT_W-1:0] txn_q, txn_d;

  logic  push, load, hs;
  pair_t head;

  // in_ready depends only on registered level, so there is no path from out_ready.
  assign in_ready = (level_q != LVL_W'(DEPTH));
  assign push     = in_valid & in_ready;
  assign hs       = out_valid_q & out_ready;
  assign load     = (level_q != '0) & (~out_valid_q | out_ready);
  assign head     = mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    out_valid_d = out_valid_q;
    out_y_d     = out_y_q;
    txn_d       = txn_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (load) begin
      rd_ptr_d    = rd_ptr_q + PTR_W'(1);
      out_y_d     = head.a | head.b;
      out_valid_d = 1'b1;
    end else if (hs) begin
      out_valid_d = 1'b0;
    end
    level_d = level_q + LVL_W'(push) - LVL_W'(load);
    if (hs) txn_d = txn_q + CNT_W'(1);
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      txn_q       <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
      txn_q       <= txn_d;
    end
  end

  // NOTE: the storage array is not reset; the pointers and level decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{a: in_a, b: in_b};
  end

  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign level     = level_q;
  assign txn_count = txn_q;

endmodule

// File: tb/tb_or_in_stage.sv
// Directed bench for or_in_stage (WIDTH=1, DEPTH=4, CNT_W=4) with hand-computed expectations.
module tb_or_in_stage;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [0:0] in_a = '0;
  logic [0:0] in_b = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [0:0] out_y;
  logic [2:0] level;
  logic [3:0] txn_count;

  int n_cmp = 0;
  int n_bad = 0;

  or_in_stage #(.WIDTH(1), .DEPTH(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .level(level), .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic a, input logic b);
    in_valid = v;
    in_a     = a;
    in_b     = b;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Backpressure pairs and their OR results, delivered in this order.
  logic [1:0] bp_pair [6] = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b11};
  logic       bp_res  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic       tt_res  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    // Reset state
    do_reset();
    check("rst_level", level, 0);
    check("rst_valid", out_valid, 0);
    check("rst_y", out_y, 0);
    check("rst_txn", txn_count, 0);
    check("rst_ready", in_ready, 1);

    // Single pair, 2-cycle latency
    out_ready = 1'b1;
    drive(1'b1, 1'b1, 1'b0);
    tick();
    check("single_e1_valid", out_valid, 0);
    check("single_e1_level", level, 1);
    drive(1'b0, 1'b0, 1'b0);
    tick();
    check("single_e2_valid", out_valid, 1);
    check("single_e2_y", out_y, 1);
    tick();
    check("single_e3_valid", out_valid, 0);
    check("single_e3_y_hold", out_y, 1);
    check("single_e3_txn", txn_count, 1);

    // Truth table back-to-back
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, i[1], i[0]);
      tick();
      check("tt_level", level, 1);
      if (i > 0) begin
        check("tt_valid", out_valid, 1);
        check("tt_y", out_y, tt_res[i-1]);
      end
    end
    drive(1'b0, 1'b0, 1'b0);
    tick();
    check("tt_last_y", out_y, tt_res[3]);
    check("tt_last_level", level, 0);
    tick();
    check("tt_drain_valid", out_valid, 0);
    check("tt_txn", txn_count, 4);

    // Backpressure: 5 accepted, 6th held off
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_ready_before_push", in_ready, 1);
      drive(1'b1, bp_pair[i][1], bp_pair[i][0]);
      tick();
    end
    check("bp_level_full", level, 4);
    check("bp_ready_full", in_ready, 0);
    check("bp_valid", out_valid, 1);
    check("bp_y_head", out_y, bp_res[0]);
    drive(1'b1, bp_pair[5][1], bp_pair[5][0]);
    tick();
    check("bp_hold_level", level, 4);
    check("bp_hold_y", out_y, bp_res[0]);
    check("bp_hold_txn", txn_count, 0);

    // Full plus simultaneous pop: no push this edge
    out_ready = 1'b1;
    tick();
    check("fullpop_level", level, 3);
    check("fullpop_ready", in_ready, 1);
    check("fullpop_y", out_y, bp_res[1]);
    check("fullpop_txn", txn_count, 1);
    tick();
    check("bp_push6_level", level, 3);
    check("bp_y2", out_y, bp_res[2]);
    drive(1'b0, 1'b0, 1'b0);
    for (int i = 3; i < 6; i++) begin
      tick();
      check("bp_stream_valid", out_valid, 1);
      check("bp_stream_y", out_y, bp_res[i]);
      check("bp_stream_level", level, 5 - i);
    end
    tick();
    check("bp_drain_valid", out_valid, 0);
    check("bp_txn", txn_count, 6);

    // Reset mid-stream
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b1);
      tick();
    end
    check("mid_pre_level", level, 3);
    check("mid_pre_valid", out_valid, 1);
    check("mid_pre_txn", txn_count, 6);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    check("mid_rst_level", level, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_y", out_y, 0);
    check("mid_rst_txn", txn_count, 0);
    out_ready = 1'b1;
    drive(1'b1, 1'b1, 1'b1);
    tick();
    check("mid_post_e1_valid", out_valid, 0);
    drive(1'b0, 1'b0, 1'b0);
    tick();
    check("mid_post_e2_valid", out_valid, 1);
    check("mid_post_e2_y", out_y, 1);
    tick();
    check("mid_post_no_stale_valid", out_valid, 0);
    check("mid_post_no_stale_level", level, 0);
    check("mid_post_txn", txn_count, 1);

    // Counter wrap with CNT_W=4: 17 streamed results
    do_reset();
    out_ready = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      if (k <= 17) drive(1'b1, k[0], 1'b0);
      else         drive(1'b0, 1'b0, 1'b0);
      tick();
      // pair pushed at edge j carries a=j&1 and is shown after edge j+1
      if (k >= 2 && k <= 18) check("wrap_y", out_y, (k - 1) & 1);
      if (k == 17) check("wrap_txn_15", txn_count, 15);
      if (k == 18) check("wrap_txn_0", txn_count, 0);
      if (k == 19) check("wrap_txn_1", txn_count, 1);
    end
    tick();
    check("wrap_final_valid", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
